// File: rtl/seg7_counter_mux_if.sv
// Purpose: control inputs and display/counter outputs of the seg7 counter/mux block.
// Latency: none (wiring only).
// Backpressure: none; the driver side may change controls every cycle.
interface seg7_counter_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      ena;
    logic                      count_en;
    logic                      up_dn;
    logic                      hex_mode;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_val;
    logic [4*NUM_DIGITS-1:0]   value;
    logic                      wrap;
    logic [6:0]                seg_out;
    logic                      dp_out;
    logic [NUM_DIGITS-1:0]     digit_sel;

    modport master (
        output ena, count_en, up_dn, hex_mode, load, load_val,
        input  value, wrap, seg_out, dp_out, digit_sel
    );

    modport slave (
        input  ena, count_en, up_dn, hex_mode, load, load_val,
        output value, wrap, seg_out, dp_out, digit_sel
    );
endinterface

// File: rtl/seg7_counter_mux.sv
// Purpose: N-digit BCD/hex up/down counter with time-multiplexed 7-segment scan drive.
// Latency: value updates the edge after a tick; display registers follow value/scan one edge later.
// Backpressure: none; ena=0 freezes every register, outputs hold.
module seg7_counter_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 1000,
    parameter int SCAN_DIV     = 16,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    seg7_counter_mux_if.slave  ctl
);
    localparam int VW = 4 * NUM_DIGITS;
    localparam int PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
    localparam int SW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc_q;
    logic [VW-1:0]         value_q;
    logic [VW-1:0]         value_nxt;
    logic                  wrap_q;
    logic                  wrap_nxt;
    logic                  tick;
    logic                  need_sanitize;
    logic                  carry;
    logic [3:0]            digit;
    logic [3:0]            digit_max;
    logic [SW-1:0]         scan_cnt_q;
    logic [IW-1:0]         scan_idx_q;
    logic [3:0]            cur_digit;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] sel_q;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick      = ctl.count_en && (presc_q == PRESC_MAX);
    assign digit_max = ctl.hex_mode ? 4'hF : 4'h9;

    // Next counter value: load beats sanitize beats a tick step; carry out of the top digit is the wrap.
    always_comb begin
        value_nxt     = value_q;
        wrap_nxt      = 1'b0;
        need_sanitize = 1'b0;
        carry         = 1'b1;
        digit         = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!ctl.hex_mode && (value_q[4*i +: 4] > 4'd9)) begin
                need_sanitize = 1'b1;
            end
        end
        if (ctl.load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit = ctl.load_val[4*i +: 4];
                if (!ctl.hex_mode && (digit > 4'd9)) begin
                    digit = 4'd9;
                end
                value_nxt[4*i +: 4] = digit;
            end
        end else if (need_sanitize) begin
            // Digits left over from hex mode are zeroed; no carry, no wrap, the tick is dropped.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (value_q[4*i +: 4] > 4'd9) begin
                    value_nxt[4*i +: 4] = 4'h0;
                end
            end
        end else if (tick) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit = value_q[4*i +: 4];
                if (carry) begin
                    if (ctl.up_dn) begin
                        if (digit == digit_max) begin
                            digit = 4'h0;
                        end else begin
                            digit = digit + 4'h1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (digit == 4'h0) begin
                            digit = digit_max;
                        end else begin
                            digit = digit - 4'h1;
                            carry = 1'b0;
                        end
                    end
                end
                value_nxt[4*i +: 4] = digit;
            end
            wrap_nxt = carry;
        end
    end

    // Prescaler, counter value and wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            value_q <= '0;
            wrap_q  <= 1'b0;
        end else if (ctl.ena) begin
            if (ctl.load) begin
                presc_q <= '0;
            end else if (ctl.count_en) begin
                presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
            end
            value_q <= value_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

    // Scan timer: each digit is driven for SCAN_DIV cycles, regardless of counting or loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
        end else if (ctl.ena) begin
            if (scan_cnt_q == SCAN_MAX) begin
                scan_cnt_q <= '0;
                scan_idx_q <= (scan_idx_q == IDX_MAX) ? '0 : scan_idx_q + IW'(1);
            end else begin
                scan_cnt_q <= scan_cnt_q + SW'(1);
            end
        end
    end

    // Select the nibble currently being scanned.
    always_comb begin
        cur_digit = value_q[3:0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IW'(i)) begin
                cur_digit = value_q[4*i +: 4];
            end
        end
    end

    // Display registers, held active-high; panel polarity is applied at the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= 7'h3F;
            dp_q  <= 1'b0;
            sel_q <= NUM_DIGITS'(1);
        end else if (ctl.ena) begin
            seg_q <= seg_decode(cur_digit);
            dp_q  <= (scan_idx_q == '0) && !ctl.up_dn;
            sel_q <= NUM_DIGITS'(1) << scan_idx_q;
        end
    end

    assign ctl.value     = value_q;
    assign ctl.wrap      = wrap_q;
    assign ctl.seg_out   = seg_q ^ {7{COMMON_ANODE}};
    assign ctl.dp_out    = dp_q ^ COMMON_ANODE;
    assign ctl.digit_sel = sel_q ^ {NUM_DIGITS{COMMON_ANODE}};
endmodule

// File: tb/tb_seg7_counter_mux.sv
// Purpose: scoreboard bench for seg7_counter_mux (2-digit common-cathode and 4-digit common-anode).
// Latency: expectations are queued after each rising edge and compared at the following falling edge.
// Backpressure: none; the monitor drains the queue every falling edge.
module tb_seg7_counter_mux;
    logic clk = 1'b0;
    logic rst2;
    logic rst4;

    always #5 clk = ~clk;

    seg7_counter_mux_if #(.NUM_DIGITS(2)) if2 ();
    seg7_counter_mux_if #(.NUM_DIGITS(4)) if4 ();

    seg7_counter_mux #(.NUM_DIGITS(2), .TICK_DIV(2), .SCAN_DIV(4), .COMMON_ANODE(1'b0)) dut2 (
        .clk (clk),
        .rst (rst2),
        .ctl (if2.slave)
    );

    seg7_counter_mux #(.NUM_DIGITS(4), .TICK_DIV(3), .SCAN_DIV(4), .COMMON_ANODE(1'b1)) dut4 (
        .clk (clk),
        .rst (rst4),
        .ctl (if4.slave)
    );

    localparam int K2_VAL  = 0;
    localparam int K2_WRAP = 1;
    localparam int K2_SEG  = 2;
    localparam int K2_DP   = 3;
    localparam int K2_SEL  = 4;
    localparam int K4_VAL  = 5;
    localparam int K4_WRAP = 6;
    localparam int K4_SEG  = 7;
    localparam int K4_DP   = 8;
    localparam int K4_SEL  = 9;

    typedef struct {
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [15:0] actual(input int kind);
        case (kind)
            K2_VAL:  return {8'h00, if2.value};
            K2_WRAP: return {15'h0, if2.wrap};
            K2_SEG:  return {9'h0, if2.seg_out};
            K2_DP:   return {15'h0, if2.dp_out};
            K2_SEL:  return {14'h0, if2.digit_sel};
            K4_VAL:  return if4.value;
            K4_WRAP: return {15'h0, if4.wrap};
            K4_SEG:  return {9'h0, if4.seg_out};
            K4_DP:   return {15'h0, if4.dp_out};
            default: return {12'h0, if4.digit_sel};
        endcase
    endfunction

    // Monitor: pop every expectation queued since the last rising edge and compare.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [15:0] act;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = actual(e.kind);
            n_checks++;
            if (act !== e.val) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.val, $time);
            end
        end
    end

    task automatic push_exp(input int kind, input logic [15:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input int kind, input logic [15:0] val, input string name);
        logic [15:0] act;
        act = actual(kind);
        n_checks++;
        if (act !== val) begin
            n_errors++;
            $display("FAIL %s (immediate): got %h expected %h at %0t", name, act, val, $time);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] bcd2(input int k);
        return 16'((k / 10) * 16 + (k % 10));
    endfunction

    // Scan phase k counts edges since the load that followed a reset; display shows idx of phase k-1.
    task automatic scan_run(input bit big, input int k0, input int k1, input logic [15:0] val,
                            input bit down);
        int         nd;
        int         idx;
        logic [3:0] dig;
        logic [6:0] seg;
        logic [3:0] sel;
        logic       dp;
        nd = big ? 4 : 2;
        for (int k = k0; k <= k1; k++) begin
            tick_clk();
            idx = ((k - 1) / 4) % nd;
            dig = val[idx*4 +: 4];
            seg = seg_tab[dig];
            sel = 4'(1 << idx);
            dp  = (idx == 0) && down;
            if (big) begin
                push_exp(K4_SEG, {9'h0, ~seg}, "scan4_seg");
                push_exp(K4_SEL, {12'h0, ~sel}, "scan4_sel");
                push_exp(K4_DP,  {15'h0, ~dp}, "scan4_dp");
                push_exp(K4_VAL, val, "scan4_val");
            end else begin
                push_exp(K2_SEG, {9'h0, seg}, "scan2_seg");
                push_exp(K2_SEL, {14'h0, sel[1:0]}, "scan2_sel");
                push_exp(K2_DP,  {15'h0, dp}, "scan2_dp");
            end
        end
    endtask

    initial begin
        if2.ena = 1'b0; if2.count_en = 1'b0; if2.up_dn = 1'b1; if2.hex_mode = 1'b0;
        if2.load = 1'b0; if2.load_val = '0;
        if4.ena = 1'b0; if4.count_en = 1'b0; if4.up_dn = 1'b1; if4.hex_mode = 1'b0;
        if4.load = 1'b0; if4.load_val = '0;
        rst2 = 1'b1;
        rst4 = 1'b1;

        // Reset with ena=0: reset must still win.
        tick_clk();
        check_now(K2_VAL, 16'h0000, "rst2_val");
        check_now(K2_WRAP, 16'h0, "rst2_wrap");
        check_now(K2_SEG, 16'h003F, "rst2_seg");
        check_now(K2_SEL, 16'h0001, "rst2_sel");
        check_now(K2_DP, 16'h0, "rst2_dp");
        check_now(K4_VAL, 16'h0000, "rst4_val");
        check_now(K4_SEG, 16'h0040, "rst4_seg");
        check_now(K4_SEL, 16'h000E, "rst4_sel");
        check_now(K4_DP, 16'h1, "rst4_dp");
        rst2 = 1'b0;
        rst4 = 1'b0;

        // Decimal up count 00..99 then wrap to 00 with a single-cycle wrap pulse (TICK_DIV=2).
        if2.ena = 1'b1; if2.count_en = 1'b1; if2.up_dn = 1'b1; if2.hex_mode = 1'b0;
        for (int e = 1; e <= 201; e++) begin
            tick_clk();
            push_exp(K2_VAL, bcd2((e / 2) % 100), "dec_up_val");
            push_exp(K2_WRAP, {15'h0, (e == 200)}, "dec_up_wrap");
        end

        // Hex down from 00: load (overriding a pending tick), then 00 -> FF with wrap, then FE.
        if2.hex_mode = 1'b1; if2.up_dn = 1'b0; if2.load = 1'b1; if2.load_val = 8'h00;
        tick_clk();
        push_exp(K2_VAL, 16'h0000, "hex_dn_load");
        push_exp(K2_WRAP, 16'h0, "hex_dn_load_wrap");
        if2.load = 1'b0;
        tick_clk();
        check_now(K2_VAL, 16'h0000, "hex_dn_wait");
        tick_clk();
        push_exp(K2_VAL, 16'h00FF, "hex_dn_under");
        push_exp(K2_WRAP, 16'h1, "hex_dn_wrap");
        tick_clk();
        push_exp(K2_VAL, 16'h00FF, "hex_dn_hold");
        push_exp(K2_WRAP, 16'h0, "hex_dn_wrap_clr");
        tick_clk();
        push_exp(K2_VAL, 16'h00FE, "hex_dn_fe");
        push_exp(K2_WRAP, 16'h0, "hex_dn_fe_wrap");

        // Mid-scan reset then 2-digit common-cathode scan of 0x12.
        rst2 = 1'b1;
        tick_clk();
        push_exp(K2_VAL, 16'h0000, "rst2_mid_val");
        push_exp(K2_SEG, 16'h003F, "rst2_mid_seg");
        push_exp(K2_SEL, 16'h0001, "rst2_mid_sel");
        rst2 = 1'b0;
        if2.count_en = 1'b0; if2.up_dn = 1'b1; if2.load = 1'b1; if2.load_val = 8'h12;
        tick_clk();
        push_exp(K2_VAL, 16'h0012, "scan2_load");
        if2.load = 1'b0;
        scan_run(1'b0, 2, 17, 16'h0012, 1'b0);

        // Load while a tick is pending takes no step; decimal load clamps nibbles; prescaler restarts.
        if4.ena = 1'b1; if4.count_en = 1'b1; if4.up_dn = 1'b1; if4.hex_mode = 1'b1;
        tick_clk();
        push_exp(K4_VAL, 16'h0000, "pre1_val");
        tick_clk();
        push_exp(K4_VAL, 16'h0000, "pre2_val");
        if4.load = 1'b1; if4.load_val = 16'h1234;
        tick_clk();
        push_exp(K4_VAL, 16'h1234, "load_on_tick");
        if4.load = 1'b0;
        tick_clk();
        push_exp(K4_VAL, 16'h1234, "load_hold");
        if4.hex_mode = 1'b0; if4.load = 1'b1; if4.load_val = 16'h00A9;
        tick_clk();
        push_exp(K4_VAL, 16'h0099, "dec_load_clamp");
        if4.load = 1'b0;
        tick_clk();
        push_exp(K4_VAL, 16'h0099, "presc_clr1");
        tick_clk();
        push_exp(K4_VAL, 16'h0099, "presc_clr2");
        tick_clk();
        push_exp(K4_VAL, 16'h0100, "dec_carry");
        push_exp(K4_WRAP, 16'h0, "dec_carry_wrap");

        // Hex 0x00A5 then switch to decimal on a tick cycle: A zeroed, tick dropped, no wrap.
        if4.hex_mode = 1'b1; if4.load = 1'b1; if4.load_val = 16'h00A5;
        tick_clk();
        push_exp(K4_VAL, 16'h00A5, "san_load");
        if4.load = 1'b0;
        tick_clk();
        push_exp(K4_VAL, 16'h00A5, "san_wait1");
        tick_clk();
        push_exp(K4_VAL, 16'h00A5, "san_wait2");
        if4.hex_mode = 1'b0;
        tick_clk();
        push_exp(K4_VAL, 16'h0005, "sanitize");
        push_exp(K4_WRAP, 16'h0, "sanitize_wrap");
        tick_clk();
        check_now(K4_VAL, 16'h0005, "san_after");

        // Mid-scan reset, then 4-digit common-anode scan of 0x1234 with down indicator.
        rst4 = 1'b1;
        tick_clk();
        push_exp(K4_VAL, 16'h0000, "rst4_mid_val");
        push_exp(K4_SEG, 16'h0040, "rst4_mid_seg");
        push_exp(K4_SEL, 16'h000E, "rst4_mid_sel");
        push_exp(K4_WRAP, 16'h0, "rst4_mid_wrap");
        rst4 = 1'b0;
        if4.count_en = 1'b0; if4.up_dn = 1'b0; if4.hex_mode = 1'b1;
        if4.load = 1'b1; if4.load_val = 16'h1234;
        tick_clk();
        push_exp(K4_VAL, 16'h1234, "scan4_load");
        if4.load = 1'b0;
        scan_run(1'b1, 2, 17, 16'h1234, 1'b1);

        // ena=0 for 50 cycles with counting requested: everything holds (digit 0 "4" inverted = 19).
        if4.ena = 1'b0; if4.count_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick_clk();
            push_exp(K4_VAL, 16'h1234, "frz_val");
            push_exp(K4_SEL, 16'h000E, "frz_sel");
            push_exp(K4_SEG, 16'h0019, "frz_seg");
        end
        if4.ena = 1'b1; if4.count_en = 1'b0;
        scan_run(1'b1, 18, 21, 16'h1234, 1'b1);

        rst4 = 1'b1;
        tick_clk();
        push_exp(K4_VAL, 16'h0000, "rst4_end_val");
        push_exp(K4_SEL, 16'h000E, "rst4_end_sel");
        push_exp(K4_SEG, 16'h0040, "rst4_end_seg");
        rst4 = 1'b0;

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        if (n_errors == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end
endmodule
